// File: rtl/gate_vector_checker.sv
// gate_vector_checker: response-side checker for exhaustive gate tests.
// It takes (input vector, observed output) samples over valid/ready and
// compares each one against the truth table TRUTH. It counts mismatches and
// accepted samples, tracks which vectors have been covered, and reports
// pass/fail at the end of each run.
// Optional macro GVC_FIRST_FAIL_EN adds a capture of the first mismatching
// sample (ff_valid/ff_vec/ff_out/ff_idx).
module gate_vector_checker #(
    parameter int                   N_IN  = 2,
    parameter logic [2**N_IN-1:0]   TRUTH = 4'b0111,
    parameter int                   CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 in_out,
    input  logic                 in_last,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     smp_cnt,
    output logic [2**N_IN-1:0]   seen_mask
`ifdef GVC_FIRST_FAIL_EN
    ,
    output logic                 ff_valid,
    output logic [N_IN-1:0]      ff_vec,
    output logic                 ff_out,
    output logic [CNT_W-1:0]     ff_idx
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    // One-deep pipeline stage that holds the sample transferred last cycle
    logic            p_vld;
    logic [N_IN-1:0] p_vec;
    logic            p_out;

    logic                xfer;
    logic                start_run;
    logic                mism;
    logic [CNT_W-1:0]    err_nx;
    logic [CNT_W-1:0]    smp_nx;
    logic [2**N_IN-1:0]  seen_nx;

    assign xfer      = in_valid && in_ready;
    assign start_run = start && (state == S_IDLE || state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DRAIN);

    // Next-state logic and the retire-side values of the counters. The DRAIN
    // cycle uses the *_nx values so pass already includes the last sample.
    always_comb begin
        state_nx = state;
        mism     = 1'b0;
        err_nx   = err_cnt;
        smp_nx   = smp_cnt;
        seen_nx  = seen_mask;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_RUN;
            S_RUN:          if (xfer && in_last) state_nx = S_DRAIN;
            S_DRAIN:        state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
        if (p_vld) begin
            mism           = (p_out != TRUTH[p_vec]);
            seen_nx[p_vec] = 1'b1;
            if (smp_cnt != CNT_MAX)        smp_nx = smp_cnt + CNT_W'(1);
            if (mism && err_cnt != CNT_MAX) err_nx = err_cnt + CNT_W'(1);
        end
    end

    // State, handshake, pipeline stage and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            p_vld     <= 1'b0;
            p_vec     <= '0;
            p_out     <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            smp_cnt   <= '0;
            seen_mask <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == S_RUN);
            p_vld    <= xfer;
            if (xfer) begin
                p_vec <= in_vec;
                p_out <= in_out;
            end
            if (start_run) begin
                done      <= 1'b0;
                pass      <= 1'b0;
                err_cnt   <= '0;
                smp_cnt   <= '0;
                seen_mask <= '0;
            end else begin
                err_cnt   <= err_nx;
                smp_cnt   <= smp_nx;
                seen_mask <= seen_nx;
                if (state == S_DRAIN) begin
                    done <= 1'b1;
                    pass <= (err_nx == '0) && (&seen_nx);
                end
            end
        end
    end

`ifdef GVC_FIRST_FAIL_EN
    // Capture the first mismatch of a run, together with its sample index
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            ff_valid <= 1'b0;
            ff_vec   <= '0;
            ff_out   <= 1'b0;
            ff_idx   <= '0;
        end else if (p_vld && mism && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_vec   <= p_vec;
            ff_out   <= p_out;
            ff_idx   <= smp_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed, table-driven bench for gate_vector_checker (NAND, N_IN=2, CNT_W=8).
module tb_gate_vector_checker;

    localparam logic [3:0] GOLD = 4'b0111;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_out, in_last;
    logic [1:0] in_vec;
    logic       in_ready, busy, done, pass;
    logic [7:0] err_cnt, smp_cnt;
    logic [3:0] seen_mask;
`ifdef GVC_FIRST_FAIL_EN
    logic       ff_valid, ff_out;
    logic [1:0] ff_vec;
    logic [7:0] ff_idx;
`endif

    int total = 0;
    int bad   = 0;

    gate_vector_checker #(.N_IN(2), .TRUTH(4'b0111), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_vec(in_vec), .in_out(in_out),
        .in_last(in_last), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .smp_cnt(smp_cnt), .seen_mask(seen_mask)
`ifdef GVC_FIRST_FAIL_EN
        , .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_out(ff_out), .ff_idx(ff_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              n;
        logic [3:0][1:0] vecs;
        logic [3:0]      outs;
        int              e_err;
        int              e_smp;
        int              e_seen;
        int              e_pass;
        int              e_ffv;
        int              e_ffvec;
        int              e_ffout;
        int              e_ffidx;
    } run_t;

    run_t tbl[4];

    function automatic run_t mk(string nm, int n,
                                logic [1:0] v0, logic [1:0] v1, logic [1:0] v2, logic [1:0] v3,
                                logic o0, logic o1, logic o2, logic o3,
                                int er, int sm, int se, int ps,
                                int fv, int fvec, int fout, int fidx);
        run_t r;
        r.name = nm; r.n = n;
        r.vecs = {v3, v2, v1, v0};
        r.outs = {o3, o2, o1, o0};
        r.e_err = er; r.e_smp = sm; r.e_seen = se; r.e_pass = ps;
        r.e_ffv = fv; r.e_ffvec = fvec; r.e_ffout = fout; r.e_ffidx = fidx;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [1:0] v, input logic o, input logic l);
        int k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_ready_timeout", 0, 1);
        in_valid = 1'b1; in_vec = v; in_out = o; in_last = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", int'(in_ready), 1);
    endtask

    task automatic chk_res(input string nm, input int er, input int sm,
                           input int se, input int ps);
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_err"},  int'(err_cnt), er);
        chk({nm, "_smp"},  int'(smp_cnt), sm);
        chk({nm, "_seen"}, int'(seen_mask), se);
        chk({nm, "_pass"}, int'(pass), ps);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic run_tbl(input run_t r);
        do_start();
        chk({r.name, "_busy_run"}, int'(busy), 1);
        for (int i = 0; i < r.n; i++)
            send(r.vecs[i], r.outs[i], i == r.n - 1);
        chk({r.name, "_done_early"}, int'(done), 0);
        @(negedge clk);
        chk_res(r.name, r.e_err, r.e_smp, r.e_seen, r.e_pass);
`ifdef GVC_FIRST_FAIL_EN
        chk({r.name, "_ffv"}, int'(ff_valid), r.e_ffv);
        if (r.e_ffv != 0) begin
            chk({r.name, "_ffvec"}, int'(ff_vec), r.e_ffvec);
            chk({r.name, "_ffout"}, int'(ff_out), r.e_ffout);
            chk({r.name, "_ffidx"}, int'(ff_idx), r.e_ffidx);
        end
`endif
    endtask

    initial begin
        tbl[0] = mk("nand_ok",  4, 0, 1, 2, 3, 1, 1, 1, 0, 0, 4, 15, 1, 0, 0, 0, 0);
        tbl[1] = mk("faulty",   4, 0, 1, 2, 3, 0, 0, 0, 1, 4, 4, 15, 0, 1, 0, 0, 0);
        tbl[2] = mk("hole",     4, 0, 1, 1, 2, 1, 1, 1, 1, 0, 4, 7,  0, 0, 0, 0, 0);
        tbl[3] = mk("rev_err1", 4, 3, 2, 1, 0, 0, 1, 0, 1, 1, 4, 15, 0, 1, 1, 0, 2);

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_out = 1'b0; in_last = 1'b0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_pass",  int'(pass), 0);
        chk("rst_err",   int'(err_cnt), 0);
        chk("rst_smp",   int'(smp_cnt), 0);
        chk("rst_seen",  int'(seen_mask), 0);
        rst = 1'b0;
        @(negedge clk);
        // in_valid while idle has no effect
        in_valid = 1'b1; in_vec = 2'd1; in_out = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_valid_smp", int'(smp_cnt), 0);
        chk("idle_ready", int'(in_ready), 0);

        // Table runs (back-to-back samples)
        for (int t = 0; t < 4; t++) run_tbl(tbl[t]);

        // Handshake stall with start pulses mid-run and in DRAIN
        do_start();
        send(2'd0, 1'b1, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        send(2'd1, 1'b1, 1'b0);
        @(negedge clk);
        send(2'd2, 1'b1, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("stall_busy", int'(busy), 1);
        send(2'd3, 1'b0, 1'b1);
        start = 1'b1;            // lands in DRAIN, must be ignored
        chk("stall_done_early", int'(done), 0);
        @(negedge clk);
        start = 1'b0;
        chk_res("stall", 0, 4, 15, 1);
        @(negedge clk);
        chk("stall_done_held", int'(done), 1);
        // in_valid in DONE has no effect
        in_valid = 1'b1; in_vec = 2'd3; in_out = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done_valid_smp", int'(smp_cnt), 4);
        chk("done_valid_err", int'(err_cnt), 0);

        // Reset mid-run after two transfers
        do_start();
        chk("restart_clr_done", int'(done), 0);
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_err",   int'(err_cnt), 0);
        chk("mid_rst_smp",   int'(smp_cnt), 0);
        chk("mid_rst_seen",  int'(seen_mask), 0);
        @(negedge clk);
        chk("mid_rst_pipe_smp", int'(smp_cnt), 0);
        run_tbl(tbl[0]);

        // Saturation: 260 wrong samples, counters stop at 255
        do_start();
        for (int i = 0; i < 260; i++)
            send(2'(i % 4), ~GOLD[i % 4], i == 259);
        @(negedge clk);
        chk_res("sat", 255, 255, 15, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
